if_fetch: RTL

Instruction-fetch stage sitting directly upstream of the instruction ROM and downstream of the branch-resolution logic. Owns the program counter, drives the ROM chip-enable/address pair, captures the returned instruction word in the same cycle, and buffers `{pc, inst}` pairs in a small queue. The ID stage drains the queue with a valid/ready handshake. A redirect from EX flushes the queue and restarts fetch at the target.

---
 rtl/if_fetch_if.sv | 12 +
 rtl/if_fetch.sv | 118 +++++++++++
 2 files changed

// File: rtl/if_fetch_if.sv
// Fetch-to-decode channel: the head of the fetch queue, plus the ID stage's ready.
// The master side is the fetch stage; the slave side is ID.
interface if_fetch_if;
  logic        valid;
  logic        ready;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        pred_taken;

  modport master (output valid, output pc, output inst, output pred_taken, input ready);
  modport slave  (input valid, input pc, input inst, input pred_taken, output ready);
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the ROM, and queues {pc, inst} for ID.
// Optional JAL predecode redirect is enabled by defining IF_JAL_PREDICT_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  if_fetch_if.master  id
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg;
  logic [31:0]      pc_reg;
  logic [31:0]      pc_next;
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;

  logic [31:0] q_pc   [QDEPTH];
  logic [31:0] q_inst [QDEPTH];

  logic run;
  logic empty;
  logic full;
  logic pop;
  logic fetch;

  assign run   = (state_reg == RUN);
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(QDEPTH));
  assign pop   = id.valid & id.ready;
  // A pop frees a slot on the same edge, so a full queue can still accept a fetch.
  assign fetch = run & ~branch_flag_i & (~full | pop);

  assign rom_ce_o   = fetch;
  assign rom_addr_o = run ? pc_reg : 32'h0;

  assign id.valid = ~empty;
  assign id.pc    = empty ? 32'h0 : q_pc[head_reg];
  assign id.inst  = empty ? 32'h0 : q_inst[head_reg];

`ifdef IF_JAL_PREDICT_EN
  logic        jal;
  logic [31:0] jal_imm;
  logic        q_pred [QDEPTH];

  assign jal     = (rom_inst_i[6:0] == 7'b1101111);
  assign jal_imm = {{11{rom_inst_i[31]}}, rom_inst_i[31], rom_inst_i[19:12],
                    rom_inst_i[20], rom_inst_i[30:21], 1'b0};
  assign pc_next = pc_reg + (jal ? jal_imm : 32'd4);
  assign id.pred_taken = ~empty & q_pred[head_reg];

  always_ff @(posedge clk) begin
    if (!rst && fetch) begin
      q_pred[tail_reg] <= jal;
    end
  end
`else
  assign pc_next       = pc_reg + 32'd4;
  assign id.pred_taken = 1'b0;
`endif

  // Queue payload carries no reset; count_reg alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && fetch) begin
      q_pc[tail_reg]   <= pc_reg;
      q_inst[tail_reg] <= rom_inst_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: state_reg <= RUN;
        RUN: begin
          if (branch_flag_i) begin
            // Redirect wins over fetch and pop: drop everything, restart at target.
            pc_reg    <= {branch_target_i[31:2], 2'b00};
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
          end else begin
            if (fetch) begin
              tail_reg <= tail_reg + 1'b1;
              pc_reg   <= pc_next;
            end
            if (pop) begin
              head_reg <= head_reg + 1'b1;
            end
            if (fetch && !pop) begin
              count_reg <= count_reg + 1'b1;
            end else if (pop && !fetch) begin
              count_reg <= count_reg - 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
